// File: rtl/ustream_accum.sv
`default_nettype none
// ============================================================================
//  Module      : ustream_accum
//  Description : Unary-to-binary accumulator. Counts the 1s of a unary
//                bitstream over one Sobol period of 2^BITWIDTH enabled
//                samples, drives the upstream Sobol clear at window start,
//                and presents the saturated count through a single-entry
//                valid/ready output register with a sticky drop flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ustream_accum #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic                iEn,
    input  logic                iBit,
    input  logic                iClr,
    input  logic                iReady,
    output logic                oRngClr,
    output logic                oBusy,
    output logic [BITWIDTH-1:0] oResult,
    output logic                oValid,
    output logic                oDrop
);

    localparam logic [0:0]          S_IDLE     = 1'b0;
    localparam logic [0:0]          S_RUN      = 1'b1;
    localparam logic [BITWIDTH-1:0] C_CNT_LAST = {BITWIDTH{1'b1}};
    localparam logic [BITWIDTH-1:0] C_SAT_MAX  = {BITWIDTH{1'b1}};

    logic [0:0]          state_q, state_d;
    logic [BITWIDTH-1:0] cnt_q, cnt_d;
    logic [BITWIDTH:0]   ones_q, ones_d;
    logic [BITWIDTH-1:0] result_q, result_d;
    logic                valid_q, valid_d;
    logic                drop_q, drop_d;

    logic                w_complete;
    logic                w_accept;
    logic [BITWIDTH:0]   w_final;
    logic [BITWIDTH-1:0] w_final_sat;

    // Completion is the edge that takes the last sample of the window;
    // a start request is honoured in IDLE or on that same edge.
    assign w_complete  = (state_q == S_RUN) && iEn && (cnt_q == C_CNT_LAST);
    assign w_accept    = (state_q == S_IDLE) || w_complete;

    // The last sample is still on iBit at completion, so it is folded in here
    // rather than waiting one more cycle for the counter to absorb it.
    assign w_final     = ones_q + {{BITWIDTH{1'b0}}, iBit};
    assign w_final_sat = w_final[BITWIDTH] ? C_SAT_MAX : w_final[BITWIDTH-1:0];

    // State register: all flops, reset dominates everything.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ones_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ones_q   <= ones_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
        end
    end

    // Next-state and counter update: abort wins, enabled samples advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        if (iClr) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ones_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iStart) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        ones_d  = '0;
                    end
                end
                S_RUN: begin
                    if (iEn) begin
                        if (cnt_q == C_CNT_LAST) begin
                            // Window done: chain straight into the next one
                            // when a start arrives on this edge.
                            state_d = iStart ? S_RUN : S_IDLE;
                            cnt_d   = '0;
                            ones_d  = '0;
                        end else begin
                            cnt_d  = cnt_q + 1'b1;
                            ones_d = ones_q + {{BITWIDTH{1'b0}}, iBit};
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ones_d  = '0;
                end
            endcase
        end
    end

    // Output register: load on completion if the slot is free or draining,
    // otherwise flag the lost result; abort clears only the drop flag.
    always_comb begin
        result_d = result_q;
        valid_d  = valid_q;
        drop_d   = drop_q;
        if (w_complete && !iClr) begin
            if (!valid_q || iReady) begin
                result_d = w_final_sat;
                valid_d  = 1'b1;
            end else begin
                drop_d   = 1'b1;
            end
        end else if (iReady) begin
            valid_d = 1'b0;
        end
        if (iClr) begin
            drop_d = 1'b0;
        end
    end

    assign oRngClr = iStart & w_accept & ~iClr & ~iRst;
    assign oBusy   = (state_q == S_RUN);
    assign oResult = result_q;
    assign oValid  = valid_q;
    assign oDrop   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_ustream_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ustream_accum
//  Description : Self-checking bench for ustream_accum. Unary streams with a
//                known number of 1s are shuffled at random and the expected
//                result is the saturated popcount of the enabled samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ustream_accum;

    localparam int BW  = 8;
    localparam int WIN = 1 << BW;

    logic          clk;
    logic          rst;
    logic          i_start;
    logic          i_en;
    logic          i_bit;
    logic          i_clr;
    logic          i_ready;
    logic          o_rng_clr;
    logic          o_busy;
    logic [BW-1:0] o_result;
    logic          o_valid;
    logic          o_drop;

    int tests_run;
    int tests_failed;
    int cyc;
    int pos;
    bit rng_last;
    bit pat [WIN];

    ustream_accum #(.BITWIDTH(BW)) u_dut (
        .iClk    (clk),
        .iRst    (rst),
        .iStart  (i_start),
        .iEn     (i_en),
        .iBit    (i_bit),
        .iClr    (i_clr),
        .iReady  (i_ready),
        .oRngClr (o_rng_clr),
        .oBusy   (o_busy),
        .oResult (o_result),
        .oValid  (o_valid),
        .oDrop   (o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference stream: exactly b ones shuffled over the window; the expected
    // result is that population count clipped to the output width.
    task automatic make_pat(input int b, output int exp_val);
        int ones;
        for (int i = 0; i < WIN; i++) pat[i] = (i < b);
        for (int i = WIN - 1; i > 0; i--) begin
            int j;
            bit t;
            j      = $urandom_range(i, 0);
            t      = pat[i];
            pat[i] = pat[j];
            pat[j] = t;
        end
        ones = 0;
        for (int i = 0; i < WIN; i++) ones += pat[i];
        exp_val = (ones > WIN - 1) ? WIN - 1 : ones;
        pos = 0;
    endtask

    // Issue a start in IDLE; returns the combinational Sobol clear seen.
    task automatic do_start(output bit rng);
        i_start = 1'b1;
        #1;
        rng = o_rng_clr;
        tick();
        i_start = 1'b0;
    endtask

    // Feed n enabled samples from the pattern. Before each edge the block
    // must be busy and oValid must hold exp_valid; ok reports that.
    task automatic feed(input int n, input bit toggle, input bit start_last,
                        input bit ready_last, input bit exp_valid, output bit ok);
        int done;
        int guard;
        bit ph;
        bit last;
        bit rdy_save;
        done     = 0;
        guard    = 0;
        ph       = 1'b1;
        ok       = 1'b1;
        rdy_save = i_ready;
        while (done < n && guard < 4 * WIN) begin
            if (o_busy !== 1'b1 || o_valid !== exp_valid) ok = 1'b0;
            i_en = toggle ? ph : 1'b1;
            ph   = ~ph;
            last = i_en && (done == n - 1);
            if (i_en) begin
                i_bit   = pat[pos];
                i_start = last ? start_last : 1'b0;
                if (last && ready_last) i_ready = 1'b1;
            end else begin
                i_bit   = 1'($urandom);
                i_start = 1'($urandom);
            end
            #1;
            if (last) rng_last = o_rng_clr;
            tick();
            if (i_en) begin
                pos++;
                done++;
            end
            i_start = 1'b0;
            i_ready = rdy_save;
            guard++;
        end
        if (done < n) ok = 1'b0;
        i_en  = 1'b0;
        i_bit = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        i_start = 1'b1;
        #1;
        tests_run++;
        if (o_rng_clr !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rngclr: got %0b want 0", o_rng_clr);
        end
        tick();
        tick();
        i_start = 1'b0;
        tests_run++;
        if (o_result !== '0 || o_valid !== 1'b0 || o_drop !== 1'b0 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got res=%0d v=%0b d=%0b b=%0b want all 0",
                     o_result, o_valid, o_drop, o_busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_window(input int b, input bit toggle);
        int exp_val;
        bit rng;
        bit ok;
        make_pat(b, exp_val);
        i_ready = 1'b1;
        cyc     = 0;
        do_start(rng);
        tests_run++;
        if (rng !== 1'b1) begin
            tests_failed++;
            $display("FAIL win_rngclr b=%0d: got %0b want 1", b, rng);
        end
        feed(WIN, toggle, 1'b0, 1'b0, 1'b0, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL win_running b=%0d: busy/valid wrong before final sample", b);
        end
        if (!toggle) begin
            tests_run++;
            if (cyc != WIN + 1) begin
                tests_failed++;
                $display("FAIL win_latency b=%0d: got %0d cycles want %0d", b, cyc, WIN + 1);
            end
        end
        tests_run++;
        if (o_valid !== 1'b1 || o_result !== BW'(exp_val) || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL win_result b=%0d tog=%0b: got res=%0d v=%0b busy=%0b want res=%0d v=1 busy=0",
                     b, toggle, o_result, o_valid, o_busy, exp_val);
        end
        tick();
        tests_run++;
        if (o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL win_handshake b=%0d: got valid=%0b want 0", b, o_valid);
        end
    endtask

    task automatic test_back_to_back();
        int e1;
        int e2;
        int e3;
        bit rng;
        bit ok;
        i_ready = 1'b0;
        make_pat($urandom_range(WIN - 1, 1), e1);
        do_start(rng);
        feed(WIN, 1'b0, 1'b1, 1'b0, 1'b0, ok);
        tests_run++;
        if (!ok || rng_last !== 1'b1 || o_valid !== 1'b1 || o_result !== BW'(e1)
            || o_busy !== 1'b1 || o_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first: got ok=%0b rng=%0b v=%0b res=%0d busy=%0b drop=%0b want 1 1 1 %0d 1 0",
                     ok, rng_last, o_valid, o_result, o_busy, o_drop, e1);
        end
        make_pat($urandom_range(WIN - 1, 1), e2);
        feed(WIN, 1'b0, 1'b1, 1'b0, 1'b1, ok);
        tests_run++;
        if (!ok || o_valid !== 1'b1 || o_result !== BW'(e1) || o_busy !== 1'b1 || o_drop !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_drop: got ok=%0b v=%0b res=%0d busy=%0b drop=%0b want 1 1 %0d 1 1 (dropped %0d)",
                     ok, o_valid, o_result, o_busy, o_drop, e1, e2);
        end
        make_pat($urandom_range(WIN - 1, 1), e3);
        feed(WIN, 1'b1, 1'b0, 1'b1, 1'b1, ok);
        tests_run++;
        if (!ok || o_valid !== 1'b1 || o_result !== BW'(e3) || o_busy !== 1'b0 || o_drop !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_third: got ok=%0b v=%0b res=%0d busy=%0b drop=%0b want 1 1 %0d 0 1",
                     ok, o_valid, o_result, o_busy, o_drop, e3);
        end
    endtask

    task automatic test_clear();
        int exp_val;
        logic [BW-1:0] held;
        bit rng;
        bit ok;
        i_ready = 1'b0;
        held    = o_result;
        make_pat($urandom_range(WIN - 1, 1), exp_val);
        do_start(rng);
        feed(100, 1'b0, 1'b0, 1'b0, 1'b1, ok);
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        tests_run++;
        if (!ok || o_valid !== 1'b1 || o_result !== held || o_drop !== 1'b0 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_abort: got ok=%0b v=%0b res=%0d drop=%0b busy=%0b want 1 1 %0d 0 0",
                     ok, o_valid, o_result, o_drop, o_busy, held);
        end
        i_clr   = 1'b1;
        i_start = 1'b1;
        #1;
        tests_run++;
        if (o_rng_clr !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_start_rngclr: got %0b want 0", o_rng_clr);
        end
        tick();
        i_clr   = 1'b0;
        i_start = 1'b0;
        tests_run++;
        if (o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_start_idle: got busy=%0b want 0", o_busy);
        end
        i_ready = 1'b1;
        tick();
        test_window($urandom_range(WIN - 1, 0), 1'b0);
    endtask

    task automatic test_reset_mid();
        int exp_val;
        bit rng;
        bit ok;
        i_ready = 1'b0;
        make_pat($urandom_range(WIN - 1, 1), exp_val);
        do_start(rng);
        feed(WIN, 1'b0, 1'b0, 1'b0, 1'b0, ok);
        make_pat(WIN / 2, exp_val);
        do_start(rng);
        feed(50, 1'b0, 1'b0, 1'b0, 1'b1, ok);
        rst     = 1'b1;
        i_start = 1'b1;
        #1;
        tests_run++;
        if (o_rng_clr !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_rngclr: got %0b want 0", o_rng_clr);
        end
        tick();
        rst     = 1'b0;
        i_start = 1'b0;
        tests_run++;
        if (o_result !== '0 || o_valid !== 1'b0 || o_drop !== 1'b0 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_state: got res=%0d v=%0b d=%0b b=%0b want all 0",
                     o_result, o_valid, o_drop, o_busy);
        end
        test_window($urandom_range(WIN - 1, 0), 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        pos          = 0;
        rng_last     = 1'b0;
        rst          = 1'b1;
        i_start      = 1'b0;
        i_en         = 1'b0;
        i_bit        = 1'b0;
        i_clr        = 1'b0;
        i_ready      = 1'b1;
        test_reset();
        test_window(WIN, 1'b0);       // all ones: saturates
        test_window(128, 1'b0);
        test_window(0, 1'b0);
        test_window(255, 1'b0);
        test_window(37, 1'b0);
        test_window(100, 1'b1);       // iEn toggling
        for (int k = 0; k < 3; k++) test_window($urandom_range(WIN, 0), 1'($urandom));
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
